store_buffer: RTL and testbench



---
 rtl/store_buffer.sv | 110 +++++++++++
 tb/tb_store_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write buffer: queues core stores, drains them in order over a req/ack
// memory port, and forwards the youngest pending store to matching loads.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    output logic          st_stall,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_hit,
    output logic [DW-1:0] ld_data,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    output logic          empty,
    output logic [CW-1:0] count
);

    // state | meaning
    // IDLE  | nothing being offered to memory
    // REQ   | head entry presented on mem_*, waiting for mem_ack
    typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

    localparam int PW = $clog2(DEPTH);

    logic [AW-3:0] r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_empty;
    state_t        r_state;

    state_t        w_state_nxt;
    logic          w_enq;
    logic          w_pop;
    logic [CW-1:0] w_count_nxt;
    logic          w_ld_hit;
    logic [DW-1:0] w_ld_data;
    logic          w_unused;

    // Word stores only; byte offsets carry no information here.
    assign w_unused = ^{st_addr[1:0], ld_addr[1:0]};

    assign st_stall    = (r_count == CW'(DEPTH));
    assign w_enq       = st_valid & ~st_stall;
    assign w_pop       = (r_state == S_REQ) & mem_ack;
    assign w_count_nxt = r_count + CW'(w_enq) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_wptr] <= st_addr[AW-1:2];
            r_data[r_wptr] <= st_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_state <= S_IDLE;
        end else begin
            if (w_enq) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (r_count != '0) w_state_nxt = S_REQ;
            S_REQ:  if (mem_ack && (w_count_nxt == '0)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        w_ld_hit  = 1'b0;
        w_ld_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < r_count) &&
                (r_addr[r_rptr + PW'(k)] == ld_addr[AW-1:2])) begin
                w_ld_hit  = 1'b1;
                w_ld_data = r_data[r_rptr + PW'(k)];
            end
        end
    end

    assign ld_hit    = w_ld_hit;
    assign ld_data   = w_ld_data;
    assign mem_req   = (r_state == S_REQ);
    assign mem_addr  = {r_addr[r_rptr], 2'b00};
    assign mem_wdata = r_data[r_rptr];
    assign empty     = r_empty;
    assign count     = r_count;

endmodule

// File: tb/tb_store_buffer.sv
// Directed and randomized checks of store_buffer against a queue-based model
// of pending stores and the drain handshake.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_stall;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic [DW-1:0] ld_data;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic          empty;
    logic [CW-1:0] count;

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_stall(st_stall),
        .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-3:0] w;
        logic [DW-1:0] d;
    } entry_t;

    entry_t q[$];
    bit     m_req;
    int     checks   = 0;
    int     failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs to the model with current inputs applied, then clock
    // once and advance the model by the same edge.
    task automatic cycle();
        logic          e_hit;
        logic [DW-1:0] e_data;
        int            size_b;
        bit            enq;
        bit            pop;
        entry_t        ne;
        #1;
        e_hit  = 1'b0;
        e_data = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].w == ld_addr[AW-1:2]) begin
                e_hit  = 1'b1;
                e_data = q[i].d;
                break;
            end
        end
        chk("count",    64'(count),    64'(q.size()));
        chk("empty",    64'(empty),    64'(q.size() == 0));
        chk("st_stall", 64'(st_stall), 64'(q.size() == DEPTH));
        chk("mem_req",  64'(mem_req),  64'(m_req));
        chk("ld_hit",   64'(ld_hit),   64'(e_hit));
        chk("ld_data",  64'(ld_data),  64'(e_data));
        if (m_req) begin
            chk("mem_addr",  64'(mem_addr),  64'({q[0].w, 2'b00}));
            chk("mem_wdata", 64'(mem_wdata), 64'(q[0].d));
        end
        size_b = q.size();
        enq    = st_valid && (size_b < DEPTH);
        pop    = m_req && mem_ack;
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_req = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (enq) begin
                ne.w = st_addr[AW-1:2];
                ne.d = st_data;
                q.push_back(ne);
            end
            m_req = m_req ? (q.size() > 0) : (size_b > 0);
        end
        #1;
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
    endtask

    task automatic do_reset();
        reset = 1'b1; st_valid = 1'b0; mem_ack = 1'b0;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_addr = '0; mem_ack = 1'b0; m_req = 1'b0;
        @(posedge clk); #1;
        cycle();
        reset = 1'b0;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_empty", 64'(empty), 64'd1);

        // Single store drained with ack tied high
        mem_ack = 1'b1;
        store(32'h64, 32'd7); cycle();
        st_valid = 1'b0;
        #1 chk("single_req", 64'(mem_req), 64'd0);
        cycle();
        chk("single_req1", 64'(mem_req), 64'd1);
        chk("single_addr", 64'(mem_addr), 64'h64);
        cycle();
        chk("single_req2", 64'(mem_req), 64'd0);
        cycle();

        // Fill past capacity, then drain one per cycle
        mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            store(32'(i * 4), 32'(100 + i)); cycle();
        end
        st_valid = 1'b0;
        #1 chk("fill_stall", 64'(st_stall), 64'd1);
        chk("fill_count", 64'(count), 64'd4);
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("drain_addr", 64'(mem_addr), 64'(i * 4));
            cycle();
        end
        cycle();
        mem_ack = 1'b0;

        // Full with simultaneous pop: store rejected, then accepted
        for (int i = 0; i < 4; i++) begin
            store(32'h200 + 32'(i * 4), 32'(i)); cycle();
        end
        st_valid = 1'b0; cycle();
        store(32'h300, 32'hAA); mem_ack = 1'b1; cycle();
        chk("fullpop_count", 64'(count), 64'd3);
        mem_ack = 1'b0; cycle();
        chk("refill_count", 64'(count), 64'd4);
        st_valid = 1'b0;
        do_reset();

        // Youngest match wins
        store(32'h60, 32'd1); cycle();
        store(32'h60, 32'd9); cycle();
        st_valid = 1'b0; ld_addr = 32'h62;
        #1 chk("fwd_hit", 64'(ld_hit), 64'd1);
        chk("fwd_data", 64'(ld_data), 64'd9);
        cycle();
        ld_addr = 32'h68; cycle();
        do_reset();

        // Same-cycle store invisible to load
        store(32'h40, 32'd5); ld_addr = 32'h40;
        #1 chk("same_cycle_hit", 64'(ld_hit), 64'd0);
        cycle();
        st_valid = 1'b0;
        #1 chk("next_cycle_data", 64'(ld_data), 64'd5);
        cycle();
        do_reset();

        // Reset mid-drain, then stale ack
        for (int i = 0; i < 3; i++) begin
            store(32'h80 + 32'(i * 4), 32'(i + 1)); cycle();
        end
        st_valid = 1'b0; cycle();
        reset = 1'b1; mem_ack = 1'b1; cycle();
        reset = 1'b0;
        chk("rst_mid_req", 64'(mem_req), 64'd0);
        chk("rst_mid_count", 64'(count), 64'd0);
        cycle(); cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset    = ($urandom_range(0, 63) == 0);
            st_valid = $urandom_range(0, 1);
            st_addr  = {24'h0, 3'($urandom_range(0, 7)), 3'b000, 2'($urandom)} | 32'h100;
            st_data  = $urandom;
            ld_addr  = {24'h0, 3'($urandom_range(0, 7)), 3'b000, 2'($urandom)} | 32'h100;
            mem_ack  = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
